fft_peak_detect: RTL and testbench

Downstream consumer of the R2 pipeline FFT output stream (dout_en/dout_cnt/dout_re/dout_im). Computes |X|^2 per bin, maps the bit-reversed output index to a natural bin index, and tracks the strongest eligible bin over each 2^N-sample frame. Once per frame it emits the peak bin index and peak power with a one-cycle valid pulse. Runs in the FFT output clock domain (50 MHz system clock).

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_mag2.sv | 75 +++++++
 rtl/fft_peak_detect.sv | 137 +++++++++++++
 tb/tb_fft_peak_detect.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT output post-processing blocks.
`timescale 1ns/1ps
package fft_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 9;
    localparam int unsigned POW_W = 2 * WIDTH;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(w)) begin
                r[int'(w) - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mag2.sv
// Two-stage pipelined |x|^2 = re^2 + im^2 with a valid bit and an opaque
// sideband word that travels alongside the data.
`timescale 1ns/1ps
module fft_mag2 #(
    parameter int unsigned WIDTH = fft_pkg::WIDTH,
    parameter int unsigned SB_W  = 1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] re_i,
    input  logic signed [WIDTH-1:0] im_i,
    input  logic [SB_W-1:0]         sb_i,
    output logic                    valid_o,
    output logic [2*WIDTH-1:0]      pow_o,
    output logic [SB_W-1:0]         sb_o
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = PW - 1;

    logic signed [PW-1:0] re_ext, im_ext;
    logic [SW-1:0]        re2_d, im2_d;
    logic [SW-1:0]        re2_q, im2_q;
    logic                 v1_q;
    logic [SB_W-1:0]      sb1_q;
    logic                 v2_q;
    logic [PW-1:0]        pow_q;
    logic [SB_W-1:0]      sb2_q;

    // Squares of signed inputs are non-negative and at most 2^(2*WIDTH-2).
    always_comb begin
        re_ext = PW'(re_i);
        im_ext = PW'(im_i);
        re2_d  = SW'(re_ext * re_ext);
        im2_d  = SW'(im_ext * im_ext);
    end

    // Stage 1: register both squares and the sideband.
    always_ff @(posedge clk) begin
        if (areset) begin
            v1_q  <= 1'b0;
            re2_q <= '0;
            im2_q <= '0;
            sb1_q <= '0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                re2_q <= re2_d;
                im2_q <= im2_d;
                sb1_q <= sb_i;
            end
        end
    end

    // Stage 2: sum in full width, so full-scale input cannot overflow.
    always_ff @(posedge clk) begin
        if (areset) begin
            v2_q  <= 1'b0;
            pow_q <= '0;
            sb2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pow_q <= PW'(re2_q) + PW'(im2_q);
                sb2_q <= sb1_q;
            end
        end
    end

    assign valid_o = v2_q;
    assign pow_o   = pow_q;
    assign sb_o    = sb2_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame spectral peak search on the FFT output stream: power per bin,
// bit-reverse index mapping, strongest-eligible-bin tracking and an index
// sequence check, with one registered result per frame.
`timescale 1ns/1ps
module fft_peak_detect import fft_pkg::*; #(
    parameter int unsigned WIDTH     = fft_pkg::WIDTH,
    parameter int unsigned N         = fft_pkg::N,
    parameter bit          BITREV    = 1'b1,
    parameter bit          SKIP_DC   = 1'b1,
    parameter bit          HALF_SPEC = 1'b1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    din_en,
    input  logic [N-1:0]            din_cnt,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic                    peak_valid,
    output logic [N-1:0]            peak_bin,
    output logic [2*WIDTH-1:0]      peak_pow,
    output logic                    frame_err
);

    localparam int unsigned PW   = 2 * WIDTH;
    // Sideband layout: {mis, last, first, elig, bin[N-1:0]}
    localparam int unsigned SB_W = N + 4;

    logic [N-1:0]    exp_q;
    logic [N-1:0]    nat_bin;
    logic            in_elig, in_first, in_last, in_mis;
    logic [SB_W-1:0] sb_in, s2_sb;
    logic            s2_valid;
    logic [PW-1:0]   s2_pow;
    logic [N-1:0]    s2_bin;
    logic            s2_elig, s2_first, s2_last, s2_mis;

    logic            cur_vld, take;
    logic [PW-1:0]   cur_pow;
    logic [N-1:0]    cur_bin;
    logic            best_vld_d, best_vld_q;
    logic [PW-1:0]   best_pow_d, best_pow_q;
    logic [N-1:0]    best_bin_d, best_bin_q;
    logic            err_d, err_q;
    logic            done_d, done_q;

    // Input decode: natural bin, eligibility, frame flags, sequence mismatch.
    always_comb begin
        nat_bin  = BITREV ? N'(bitrev(32'(din_cnt), N)) : din_cnt;
        in_elig  = !(SKIP_DC && (nat_bin == '0)) && !(HALF_SPEC && nat_bin[N-1]);
        in_first = (din_cnt == '0);
        in_last  = &din_cnt;
        in_mis   = (din_cnt != exp_q);
        sb_in    = {in_mis, in_last, in_first, in_elig, nat_bin};
    end

    // Expected-index counter; resyncs to the observed index after a mismatch.
    always_ff @(posedge clk) begin
        if (areset) begin
            exp_q <= '0;
        end else if (din_en) begin
            exp_q <= din_cnt + 1'b1;
        end
    end

    fft_mag2 #(
        .WIDTH (WIDTH),
        .SB_W  (SB_W)
    ) u_mag2 (
        .clk     (clk),
        .areset  (areset),
        .valid_i (din_en),
        .re_i    (din_re),
        .im_i    (din_im),
        .sb_i    (sb_in),
        .valid_o (s2_valid),
        .pow_o   (s2_pow),
        .sb_o    (s2_sb)
    );

    // Stage 3 next state: a first flag empties best before this sample is
    // considered; ties go to the lower natural bin.
    always_comb begin
        {s2_mis, s2_last, s2_first, s2_elig, s2_bin} = s2_sb;
        cur_vld    = s2_first ? 1'b0 : best_vld_q;
        cur_pow    = s2_first ? '0 : best_pow_q;
        cur_bin    = s2_first ? '0 : best_bin_q;
        take       = s2_elig && (!cur_vld || (s2_pow > cur_pow) ||
                                 ((s2_pow == cur_pow) && (s2_bin < cur_bin)));
        best_vld_d = best_vld_q;
        best_pow_d = best_pow_q;
        best_bin_d = best_bin_q;
        err_d      = err_q;
        done_d     = 1'b0;
        if (s2_valid) begin
            best_vld_d = cur_vld | take;
            best_pow_d = take ? s2_pow : cur_pow;
            best_bin_d = take ? s2_bin : cur_bin;
            err_d      = (s2_first ? 1'b0 : err_q) | s2_mis;
            done_d     = s2_last;
        end
    end

    // Stage 3 registers: running best, sticky error, end-of-frame marker.
    always_ff @(posedge clk) begin
        if (areset) begin
            best_vld_q <= 1'b0;
            best_pow_q <= '0;
            best_bin_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            best_vld_q <= best_vld_d;
            best_pow_q <= best_pow_d;
            best_bin_q <= best_bin_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Result registers; an empty best at end of frame reports 0/0 with error.
    always_ff @(posedge clk) begin
        if (areset) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_pow   <= '0;
            frame_err  <= 1'b0;
        end else begin
            peak_valid <= done_q;
            if (done_q) begin
                peak_bin  <= best_vld_q ? best_bin_q : '0;
                peak_pow  <= best_vld_q ? best_pow_q : '0;
                frame_err <= err_q | ~best_vld_q;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed and randomized frames checked against a per-frame reference:
// scan all sent natural bins, keep the strongest eligible (lowest bin on
// ties) and flag any break in the 0..511 index sequence.
`timescale 1ns/1ps
module tb_fft_peak_detect;

    localparam int N = 9;
    localparam int L = 512;

    logic              clk = 1'b0;
    logic              areset;
    logic              din_en;
    logic [N-1:0]      din_cnt;
    logic signed [15:0] din_re, din_im;
    logic              peak_valid;
    logic [N-1:0]      peak_bin;
    logic [31:0]       peak_pow;
    logic              frame_err;

    always #10 clk = ~clk;

    fft_peak_detect u_dut (
        .clk        (clk),
        .areset     (areset),
        .din_en     (din_en),
        .din_cnt    (din_cnt),
        .din_re     (din_re),
        .din_im     (din_im),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_pow   (peak_pow),
        .frame_err  (frame_err)
    );

    int n_cmp, n_mis, tick, model_exp;
    bit model_err;
    int fre[L], fim[L];
    bit sent[L];

    int     got_tick[$], exp_tick[$];
    longint got_bin[$],  exp_bin[$];
    longint got_pow[$],  exp_pow[$];
    longint got_err[$],  exp_err[$];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < N; i++) if (((v >> i) & 1) != 0) r |= 1 << (N - 1 - i);
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic step(input bit rst, input bit en, input int cnt, input int re, input int im);
        @(negedge clk);
        tick++;
        if (peak_valid === 1'b1) begin
            got_tick.push_back(tick);
            got_bin.push_back(longint'(peak_bin));
            got_pow.push_back(longint'(peak_pow));
            got_err.push_back(longint'(frame_err));
        end
        areset  = rst;
        din_en  = en;
        din_cnt = cnt[N-1:0];
        din_re  = re[15:0];
        din_im  = im[15:0];
    endtask

    task automatic clear_frame();
        for (int i = 0; i < L; i++) begin
            fre[i] = 0;
            fim[i] = 0;
        end
    endtask

    // Reference result for the frame just sent.
    task automatic model_push(input int last_tick);
        bit     found = 0;
        longint bp = 0;
        int     bb = 0;
        for (int nb = 1; nb < L / 2; nb++) begin
            longint p;
            if (!sent[nb]) continue;
            p = longint'(fre[nb]) * fre[nb] + longint'(fim[nb]) * fim[nb];
            if (!found || p > bp) begin
                found = 1;
                bp = p;
                bb = nb;
            end
        end
        exp_tick.push_back(last_tick + 4);
        exp_bin.push_back(found ? bb : 0);
        exp_pow.push_back(found ? bp : 0);
        exp_err.push_back((model_err || !found) ? 1 : 0);
    endtask

    // Send one frame in bit-reversed order; optional skip, gap or reset point.
    task automatic send_frame(input int skip, input int gap_at, input int gap_len,
                              input int rst_at);
        int last_tick = 0;
        for (int i = 0; i < L; i++) sent[i] = 0;
        model_err = 0;
        for (int c = 0; c < L; c++) begin
            int nb = brev(c);
            if (c == gap_at) repeat (gap_len) step(0, 0, 0, 0, 0);
            if (c == skip) continue;
            if (c == rst_at) begin
                step(1, 1, c, fre[nb], fim[nb]);
                model_exp = 0;
                return;
            end
            step(0, 1, c, fre[nb], fim[nb]);
            sent[nb] = 1;
            if (c != model_exp) model_err = 1;
            model_exp = (c + 1) % L;
            last_tick = tick;
        end
        model_push(last_tick);
    endtask

    task automatic flush();
        repeat (6) step(0, 0, 0, 0, 0);
    endtask

    task automatic verify(input string tag);
        int n;
        chk({tag, "_pulses"}, got_tick.size(), exp_tick.size());
        n = (got_tick.size() < exp_tick.size()) ? got_tick.size() : exp_tick.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_latency"}, got_tick[i], exp_tick[i]);
            chk({tag, "_bin"}, got_bin[i], exp_bin[i]);
            chk({tag, "_pow"}, got_pow[i], exp_pow[i]);
            chk({tag, "_err"}, got_err[i], exp_err[i]);
        end
        got_tick.delete(); got_bin.delete(); got_pow.delete(); got_err.delete();
        exp_tick.delete(); exp_bin.delete(); exp_pow.delete(); exp_err.delete();
    endtask

    task automatic tone37();
        clear_frame();
        fre[37] = 1000;
        fim[37] = -500;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; tick = 0; model_exp = 0; model_err = 0;
        areset = 1'b1; din_en = 1'b0; din_cnt = '0; din_re = '0; din_im = '0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_valid", longint'(peak_valid), 0);
        chk("rst_bin", longint'(peak_bin), 0);
        chk("rst_pow", longint'(peak_pow), 0);
        chk("rst_err", longint'(frame_err), 0);

        // Single tone at natural bin 37 (index 328)
        tone37();
        send_frame(-1, -1, 0, -1);
        flush();
        verify("tone");
        chk("tone_bin_hold", longint'(peak_bin), 37);
        chk("tone_pow_hold", longint'(peak_pow), 1250000);

        // Tie, DC and upper half excluded
        clear_frame();
        fre[0] = 32767; fre[300] = 5000; fre[10] = 20; fre[20] = 20;
        send_frame(-1, -1, 0, -1);
        flush();
        verify("tie");
        chk("tie_bin_hold", longint'(peak_bin), 10);
        chk("tie_pow_hold", longint'(peak_pow), 400);

        // Full-scale sample
        for (int i = 0; i < L; i++) begin
            fre[i] = 1;
            fim[i] = 0;
        end
        fre[100] = -32768; fim[100] = -32768;
        send_frame(-1, -1, 0, -1);
        flush();
        verify("fullscale");
        chk("fs_pow_hold", longint'(peak_pow), 64'd2147483648);
        chk("fs_bin_hold", longint'(peak_bin), 100);

        // Gap inside a frame, then a back-to-back frame
        tone37();
        send_frame(-1, 200, 7, -1);
        clear_frame();
        fre[5] = 3;
        send_frame(-1, -1, 0, -1);
        flush();
        verify("b2b");
        chk("b2b_bin_hold", longint'(peak_bin), 5);
        chk("b2b_pow_hold", longint'(peak_pow), 9);

        // Sequence error, then a clean frame
        tone37();
        send_frame(200, -1, 0, -1);
        flush();
        verify("seqerr");
        chk("seqerr_flag", longint'(frame_err), 1);
        tone37();
        send_frame(-1, -1, 0, -1);
        flush();
        verify("seqok");
        chk("seqok_flag", longint'(frame_err), 0);

        // Random full-range frames
        repeat (3) begin
            for (int i = 0; i < L; i++) begin
                fre[i] = int'($urandom_range(0, 65535)) - 32768;
                fim[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            send_frame(-1, -1, 0, -1);
            flush();
            verify("rand");
        end

        // Random small-amplitude frames: many equal powers, tie-break matters
        repeat (2) begin
            for (int i = 0; i < L; i++) begin
                fre[i] = int'($urandom_range(0, 6)) - 3;
                fim[i] = int'($urandom_range(0, 6)) - 3;
            end
            send_frame(-1, -1, 0, -1);
            flush();
            verify("ties");
        end

        // Reset in the middle of a frame
        tone37();
        send_frame(-1, -1, 0, 300);
        flush();
        verify("midrst");
        chk("midrst_bin", longint'(peak_bin), 0);
        chk("midrst_pow", longint'(peak_pow), 0);
        chk("midrst_err", longint'(frame_err), 0);
        tone37();
        send_frame(-1, -1, 0, -1);
        flush();
        verify("postrst");
        chk("postrst_bin_hold", longint'(peak_bin), 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
